// File: rtl/dbg_mem_arb_pkg.sv
// rtl/dbg_mem_arb_pkg.sv - shared defaults and encodings for the CPU/debug memory read arbiter
package dbg_mem_arb_pkg;

  localparam int MEM_SIZE_DEFAULT     = 128;
  localparam int STARVE_LIMIT_DEFAULT = 8;
  localparam int ADDR_W               = 8;
  localparam int DATA_W               = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } arb_owner_t;

  // True when a word address falls inside the populated memory.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int size);
    return int'(addr) < size;
  endfunction

endpackage

// File: rtl/dbg_mem_arb_starve_cnt.sv
// rtl/dbg_mem_arb_starve_cnt.sv - debug-request starvation counter with saturating count
module dbg_starve_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       gnt,
  input  logic [3:0] limit,
  output logic       starve
);

  logic [3:0] cnt;

  // Count cycles debug waits without a grant; any grant or dropped request restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (!req || gnt) begin
      cnt <= 4'd0;
    end else if (cnt != 4'hf) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Debug overrides CPU priority once it has waited limit cycles.
  always_comb begin
    starve = (cnt >= limit);
  end

endmodule

// File: rtl/dbg_mem_arb.sv
// rtl/dbg_mem_arb.sv - two-requester read arbiter in front of a synchronous memory
module dbg_mem_arb
  import dbg_mem_arb_pkg::*;
#(
  parameter int MEM_SIZE     = MEM_SIZE_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = (STARVE_LIMIT > 15) ? 4'd15 : 4'(STARVE_LIMIT);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_d;
  logic              starve;
  logic              pick_dbg;
  logic              cpu_gnt_d, dbg_gnt_d, cpu_rvalid_d, dbg_rvalid_d, mem_en_d;
  logic              rsp_valid, rsp_in_range;

  dbg_starve_cnt u_starve (
    .clk    (clk),
    .reset  (reset),
    .req    (dbg_req),
    .gnt    (dbg_gnt),
    .limit  (STARVE_LIM),
    .starve (starve)
  );

  // Next state, winner selection and the values the output flops take on the coming edge.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = mem_addr;
    pick_dbg = dbg_req && (!cpu_req || starve);
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (cpu_req || dbg_req) begin
          state_d = ST_READ;
          owner_d = pick_dbg ? OWN_DBG : OWN_CPU;
          addr_d  = pick_dbg ? dbg_addr : cpu_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
    cpu_gnt_d    = (state_d == ST_READ) && (owner_d == OWN_CPU);
    dbg_gnt_d    = (state_d == ST_READ) && (owner_d == OWN_DBG);
    mem_en_d     = (state_d == ST_READ) && addr_in_range(addr_d, MEM_SIZE);
    cpu_rvalid_d = (state_d == ST_RESP) && (owner_d == OWN_CPU);
    dbg_rvalid_d = (state_d == ST_RESP) && (owner_d == OWN_DBG);
  end

  // State, owner, captured address and registered handshake outputs; reset aborts any read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_CPU;
      mem_addr   <= '0;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      mem_en     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      mem_addr   <= addr_d;
      cpu_gnt    <= cpu_gnt_d;
      dbg_gnt    <= dbg_gnt_d;
      cpu_rvalid <= cpu_rvalid_d;
      dbg_rvalid <= dbg_rvalid_d;
      mem_en     <= mem_en_d;
    end
  end

  // Response data comes straight from memory; out-of-range reads return zero with rerr.
  always_comb begin
    rsp_valid    = cpu_rvalid || dbg_rvalid;
    rsp_in_range = addr_in_range(mem_addr, MEM_SIZE);
    rdata        = (rsp_valid && rsp_in_range) ? mem_rdata : '0;
    rerr         = rsp_valid && !rsp_in_range;
  end

endmodule

// File: tb/tb_dbg_mem_arb.sv
// tb/tb_dbg_mem_arb.sv - self-checking bench for dbg_mem_arb
module tb_dbg_mem_arb;

  localparam int MEM_SIZE     = 128;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, dbg_req = 1'b0;
  logic [7:0]  cpu_addr = 8'd0, dbg_addr = 8'd0;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, rerr, mem_en;
  logic [15:0] rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = 16'd0;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         acc;
    bit         dbg;
    logic [7:0] addr;
  } txn_t;

  txn_t       q[$];
  txn_t       g_t, r_t;
  bit         g_hit, r_hit;
  int         edge_n = 0;
  int         last_acc = -10;
  bit         last_dbg = 1'b0;
  int         wait_cnt = 0;
  logic [7:0] cur_addr = 8'd0;
  bit         dbg_gnt_prev, win_dbg;

  dbg_mem_arb #(.MEM_SIZE(MEM_SIZE), .STARVE_LIMIT(STARVE_LIMIT)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .rdata      (rdata),
    .rerr       (rerr),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: data appears the cycle after mem_en.
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    check(nm, {15'd0, act}, {15'd0, exp});
  endtask

  // Transaction model: one acceptance per edge unless one was accepted on the previous edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      edge_n   = 0;
      last_acc = -10;
      last_dbg = 1'b0;
      wait_cnt = 0;
      cur_addr = 8'd0;
    end else begin
      edge_n       = edge_n + 1;
      dbg_gnt_prev = (last_acc == edge_n - 1) && last_dbg;
      if (last_acc != edge_n - 1 && (cpu_req || dbg_req)) begin
        win_dbg = dbg_req && (!cpu_req || wait_cnt >= STARVE_LIMIT);
        cur_addr = win_dbg ? dbg_addr : cpu_addr;
        q.push_back('{edge_n, win_dbg, cur_addr});
        last_acc = edge_n;
        last_dbg = win_dbg;
      end
      if (!dbg_req || dbg_gnt_prev) wait_cnt = 0;
      else if (wait_cnt < 15) wait_cnt = wait_cnt + 1;
      while (q.size() > 0 && q[0].acc < edge_n - 2) void'(q.pop_front());
    end
  end

  // Every cycle: compare all outputs against the model (or against zero under reset).
  always @(negedge clk) begin
    if (reset) begin
      check("rst_flags", {10'd0, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en, rerr}, 16'd0);
      check("rst_rdata", rdata, 16'd0);
      check("rst_mem_addr", {8'd0, mem_addr}, 16'd0);
    end else begin
      g_hit = 1'b0;
      r_hit = 1'b0;
      foreach (q[i]) begin
        if (q[i].acc == edge_n)     begin g_hit = 1'b1; g_t = q[i]; end
        if (q[i].acc == edge_n - 1) begin r_hit = 1'b1; r_t = q[i]; end
      end
      check1("cpu_gnt", cpu_gnt, g_hit && !g_t.dbg);
      check1("dbg_gnt", dbg_gnt, g_hit && g_t.dbg);
      check1("mem_en", mem_en, g_hit && int'(g_t.addr) < MEM_SIZE);
      check("mem_addr", {8'd0, mem_addr}, {8'd0, cur_addr});
      check1("cpu_rvalid", cpu_rvalid, r_hit && !r_t.dbg);
      check1("dbg_rvalid", dbg_rvalid, r_hit && r_t.dbg);
      check("rdata", rdata, (r_hit && int'(r_t.addr) < MEM_SIZE) ? mem[r_t.addr] : 16'd0);
      check1("rerr", rerr, r_hit && int'(r_t.addr) >= MEM_SIZE);
    end
  end

  task automatic single_read(input string nm, input bit d, input logic [7:0] a,
                             input logic [15:0] ed, input logic ee, input logic eme);
    int t0, g;
    @(negedge clk);
    if (d) begin dbg_req = 1'b1; dbg_addr = a; end
    else   begin cpu_req = 1'b1; cpu_addr = a; end
    t0 = cyc;
    g  = -1;
    for (int i = 0; i < 6 && g < 0; i++) begin
      @(negedge clk);
      if (d ? dbg_gnt : cpu_gnt) g = cyc;
    end
    check({nm, "_gnt_latency"}, 16'(g - t0), 16'd1);
    check1({nm, "_mem_en"}, mem_en, eme);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
    check1({nm, "_rvalid"}, d ? dbg_rvalid : cpu_rvalid, 1'b1);
    check({nm, "_rdata"}, rdata, ed);
    check1({nm, "_rerr"}, rerr, ee);
  endtask

  initial begin
    int t0, cg, dg, n, cnt_g, cnt_r;
    int c_g, c_r, d_g, d_r;
    logic [9:0] seq;

    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'h5a3c;
    mem[5] = 16'h1234;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // CPU in-range read and debug out-of-range read
    single_read("cpu_rd5", 1'b0, 8'h05, 16'h1234, 1'b0, 1'b1);
    single_read("dbg_rd90", 1'b1, 8'h90, 16'h0000, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    // Both requesting continuously: starvation hands every fifth grant to debug
    cpu_req = 1'b1; cpu_addr = 8'd3;
    dbg_req = 1'b1; dbg_addr = 8'd7;
    seq = '0;
    n = 0;
    for (int i = 0; i < 60 && n < 10; i++) begin
      @(negedge clk);
      if (cpu_gnt) n++;
      else if (dbg_gnt) begin seq[n] = 1'b1; n++; end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    check("starve_grants", 16'(n), 16'd10);
    check("starve_order", {6'd0, seq}, 16'h0210);
    repeat (3) @(negedge clk);

    // Simultaneous pulse from idle: CPU first, debug back-to-back
    cpu_req = 1'b1; cpu_addr = 8'd10;
    dbg_req = 1'b1; dbg_addr = 8'd20;
    t0 = cyc; cg = -1; dg = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu_gnt && cg < 0) begin cg = cyc; cpu_req = 1'b0; end
      if (dbg_gnt && dg < 0) begin dg = cyc; dbg_req = 1'b0; end
    end
    check("pair_cpu_gnt_at", 16'(cg - t0), 16'd1);
    check("pair_dbg_gnt_at", 16'(dg - t0), 16'd3);

    // Request withdrawn before any edge samples it
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 8'd1;
    #2 cpu_req = 1'b0;
    cnt_g = 0;
    repeat (4) begin @(negedge clk); cnt_g += int'(cpu_gnt) + int'(dbg_gnt); end
    check("unsampled_gnts", 16'(cnt_g), 16'd0);

    // Request withdrawn right after being sampled still completes
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 8'd2;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    cnt_g = 0; cnt_r = 0;
    repeat (4) begin @(negedge clk); cnt_g += int'(cpu_gnt); cnt_r += int'(cpu_rvalid); end
    check("sampled_gnts", 16'(cnt_g), 16'd1);
    check("sampled_rvalids", 16'(cnt_r), 16'd1);

    // Reset during READ aborts the read
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 8'd9;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check1("async_rst_gnt", cpu_gnt, 1'b0);
    check1("async_rst_mem_en", mem_en, 1'b0);
    check("async_rst_mem_addr", {8'd0, mem_addr}, 16'd0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt_r = 0;
    repeat (4) begin @(negedge clk); cnt_r += int'(cpu_rvalid) + int'(dbg_rvalid) + int'(cpu_gnt); end
    check("aborted_read_events", 16'(cnt_r), 16'd0);
    single_read("post_rst_rd5", 1'b0, 8'h05, 16'h1234, 1'b0, 1'b1);

    // Mixed traffic with the hold-until-grant rule
    c_g = 0; c_r = 0; d_g = 0; d_r = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      c_g += int'(cpu_gnt); c_r += int'(cpu_rvalid);
      d_g += int'(dbg_gnt); d_r += int'(dbg_rvalid);
      if (cpu_req && cpu_gnt) cpu_req = 1'b0;
      else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_addr = 8'($urandom_range(0, 255));
      end
      if (dbg_req && dbg_gnt) dbg_req = 1'b0;
      else if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req = 1'b1; dbg_addr = 8'($urandom_range(0, 255));
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      c_g += int'(cpu_gnt); c_r += int'(cpu_rvalid);
      d_g += int'(dbg_gnt); d_r += int'(dbg_rvalid);
    end
    check("rand_cpu_gnt_vs_rvalid", 16'(c_g), 16'(c_r));
    check("rand_dbg_gnt_vs_rvalid", 16'(d_g), 16'(d_r));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
